alu_writeback: RTL and testbench
================================

# alu_writeback

Result-writeback stage directly downstream of the 16-bit ALU. It captures the ALU's lower result `R`, upper result `S`, function code and exception flag through a valid/ready handshake. It drives the register file's single write port: one write for ordinary operations, and two consecutive writes for MUL/DIV (`R` to the destination, `S` to a fixed high register). On an ALU exception it suppresses all writes, latches the faulting function code and stalls until software clears it.

## Interface
- `DATA_WIDTH`, 16, width of `R`, `S` and write data
- `ALU_CONTROL_WIDTH`, 4, width of the function code
- `REG_ADDR_WIDTH`, 4, register-file address width
- `HI_REG`, 4'd15, register that receives `S` (MUL upper half / DIV remainder)
- `clk`  in  1  sole clock; all state changes on its rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `In_Valid`  in  1  upstream result valid
- `In_Ready`  out  1  stage can accept a result this cycle
- `ALU_Ctrl`  in  ALU_CONTROL_WIDTH  function code that produced the result
- `R`  in  DATA_WIDTH  ALU lower result
- `S`  in  DATA_WIDTH  ALU upper result
- `ALU_Exception`  in  1  ALU exception for this result
- `Dest`  in  REG_ADDR_WIDTH  destination register for `R`
- `Wr_En`  out  1  register-file write strobe
- `Wr_Addr`  out  REG_ADDR_WIDTH  write address
- `Wr_Data`  out  DATA_WIDTH  write data
- `Exc_Flag`  out  1  sticky exception pending
- `Exc_Ctrl`  out  ALU_CONTROL_WIDTH  function code latched at exception
- `Exc_Clear`  in  1  clears a pending exception
- `Busy`  out  1  a write is in progress or an exception is pending

## Operation
- Function codes: MUL=4'b0001 and DIV=4'b0010 are double-write. NOP is 4'b0000. All other codes are single-write.
- A transfer occurs on a rising edge where `In_Valid && In_Ready`. On a transfer the stage latches `ALU_Ctrl`, `R`, `S`, `ALU_Exception` and `Dest`.
- States are IDLE, WR_LO, WR_HI and HALT.
- IDLE:
  - `In_Ready`=1.
  - On a transfer: if `ALU_Exception`=1, go to HALT, set `Exc_Flag`=1 and set `Exc_Ctrl`=`ALU_Ctrl`.
  - Otherwise, if the code is NOP, stay in IDLE with no write.
  - Otherwise go to WR_LO.
- WR_LO:
  - `Wr_En`=1, `Wr_Addr`=latched `Dest`, `Wr_Data`=latched `R`.
  - If the latched code is double-write, go to WR_HI with `In_Ready`=0.
  - Otherwise `In_Ready`=1. A transfer in this cycle is handled exactly as from IDLE (back-to-back). With no transfer, go to IDLE.
- WR_HI:
  - `Wr_En`=1, `Wr_Addr`=`HI_REG`, `Wr_Data`=latched `S`, `In_Ready`=0.
  - Next state is IDLE.
- HALT:
  - `Wr_En`=0, `In_Ready`=0.
  - `Exc_Clear`=1 clears `Exc_Flag`, then go to IDLE. `Exc_Ctrl` holds its value until the next exception.
- `Busy` = (state != IDLE).
- `Exc_Clear` is ignored outside HALT.
- No exception in the latched result ever produces a write. Exceptions include divide-by-zero, overflow and invalid code.
- MUL/DIV with `Dest`==`HI_REG`: both writes issue in order, so `S` is the final value of that register.
- `R`/`S` are forwarded unmodified. There is no width conversion or sign extension.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, `In_Ready`=1, `Wr_En`=0, `Wr_Addr`=0, `Wr_Data`=0, `Exc_Flag`=0, `Exc_Ctrl`=0, `Busy`=0.
  - The latched operand registers are 0.
- `Wr_En`, `Wr_Addr` and `Wr_Data` are registered.
- Latency:
  - Transfer at edge N: the `R` write is visible in the cycle after N and is committed by the register file at edge N+1.
  - For MUL/DIV, the `S` write follows in the next cycle, committed at edge N+2.
- Throughput:
  - One single-write result per cycle sustained.
  - A MUL/DIV occupies 2 cycles. The next transfer is accepted at the edge ending WR_HI's predecessor cycle +1, i.e. in IDLE.
- `In_Ready` is combinational from state and the latched code only. It never depends on `In_Valid`.
- `rst_n` asserted mid-write (WR_LO/WR_HI): `Wr_En` drops immediately, and the pending `S` write is discarded. Asserted in HALT: `Exc_Flag` clears.
- `Exc_Clear` and `In_Valid` together in HALT: no transfer that edge, because `In_Ready` is 0. The result is accepted the next cycle.

## Test plan
- ADD, R=16'h0005, Dest=3, transfer at edge N → single write of `Wr_En`=1, addr 3, data 16'h0005 in the cycle after N. No write in the following cycle.
- MUL, R=16'h2000, S=16'h0001, Dest=2 → write (2, 16'h2000) then (15, 16'h0001) on consecutive cycles. `In_Ready`=0 during the second.
- Three back-to-back AND/OR/SUB results with `In_Valid` held high → three writes on three consecutive cycles. `In_Ready` stays 1 throughout.
- DIV with `ALU_Exception`=1 → no write, `Exc_Flag`=1, `Exc_Ctrl`=4'b0010, `In_Ready`=0 held for 10 cycles. `Exc_Clear` pulse → IDLE next cycle and `Exc_Flag`=0.
- NOP (4'b0000) transfer → no write, `Busy` stays 0.
- DIV accepted, then `rst_n` low during WR_LO → `Wr_En`=0 immediately, all outputs at reset values, and no `HI_REG` write after release.

Source files
------------

// File: rtl/alu_writeback.sv
// Writeback stage behind the 16-bit ALU: turns each accepted result into one or two
// register-file writes, and freezes on an ALU exception until software clears it.
module alu_writeback #(
    parameter int DATA_WIDTH        = 16,
    parameter int ALU_CONTROL_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 4,
    parameter logic [REG_ADDR_WIDTH-1:0] HI_REG = 4'd15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         In_Valid,
    output logic                         In_Ready,
    input  logic [ALU_CONTROL_WIDTH-1:0] ALU_Ctrl,
    input  logic [DATA_WIDTH-1:0]        R,
    input  logic [DATA_WIDTH-1:0]        S,
    input  logic                         ALU_Exception,
    input  logic [REG_ADDR_WIDTH-1:0]    Dest,
    output logic                         Wr_En,
    output logic [REG_ADDR_WIDTH-1:0]    Wr_Addr,
    output logic [DATA_WIDTH-1:0]        Wr_Data,
    output logic                         Exc_Flag,
    output logic [ALU_CONTROL_WIDTH-1:0] Exc_Ctrl,
    input  logic                         Exc_Clear,
    output logic                         Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        HALT  = 2'd3
    } state_t;

    localparam logic [ALU_CONTROL_WIDTH-1:0] OP_NOP = ALU_CONTROL_WIDTH'(0);
    localparam logic [ALU_CONTROL_WIDTH-1:0] OP_MUL = ALU_CONTROL_WIDTH'(1);
    localparam logic [ALU_CONTROL_WIDTH-1:0] OP_DIV = ALU_CONTROL_WIDTH'(2);

    state_t                         state;
    logic [ALU_CONTROL_WIDTH-1:0]   ctrl_q;
    logic [DATA_WIDTH-1:0]          s_q;
    logic                           transfer;

    function automatic logic is_double(input logic [ALU_CONTROL_WIDTH-1:0] code);
        return (code == OP_MUL) || (code == OP_DIV);
    endfunction

    // R and Dest go straight into the write registers on the accepting edge, so only
    // the code (for In_Ready) and S (for the second write) need their own latches.
    assign In_Ready = (state == IDLE) || ((state == WR_LO) && !is_double(ctrl_q));
    assign transfer = In_Valid && In_Ready;
    assign Busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ctrl_q   <= '0;
            s_q      <= '0;
            Wr_En    <= 1'b0;
            Wr_Addr  <= '0;
            Wr_Data  <= '0;
            Exc_Flag <= 1'b0;
            Exc_Ctrl <= '0;
        end else begin
            Wr_En <= 1'b0;
            if (transfer) begin
                ctrl_q <= ALU_Ctrl;
                s_q    <= S;
            end
            case (state)
                IDLE, WR_LO: begin
                    if (transfer) begin
                        if (ALU_Exception) begin
                            state    <= HALT;
                            Exc_Flag <= 1'b1;
                            Exc_Ctrl <= ALU_Ctrl;
                        end else if (ALU_Ctrl == OP_NOP) begin
                            state <= IDLE;
                        end else begin
                            state   <= WR_LO;
                            Wr_En   <= 1'b1;
                            Wr_Addr <= Dest;
                            Wr_Data <= R;
                        end
                    end else if ((state == WR_LO) && is_double(ctrl_q)) begin
                        state   <= WR_HI;
                        Wr_En   <= 1'b1;
                        Wr_Addr <= HI_REG;
                        Wr_Data <= s_q;
                    end else begin
                        state <= IDLE;
                    end
                end
                WR_HI: begin
                    state <= IDLE;
                end
                HALT: begin
                    if (Exc_Clear) begin
                        Exc_Flag <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: inputs change and outputs are sampled on the falling
// edge, so every transfer happens on the rising edge in between.
module tb_alu_writeback;

    logic        clk;
    logic        rst_n;
    logic        In_Valid;
    logic        In_Ready;
    logic [3:0]  ALU_Ctrl;
    logic [15:0] R;
    logic [15:0] S;
    logic        ALU_Exception;
    logic [3:0]  Dest;
    logic        Wr_En;
    logic [3:0]  Wr_Addr;
    logic [15:0] Wr_Data;
    logic        Exc_Flag;
    logic [3:0]  Exc_Ctrl;
    logic        Exc_Clear;
    logic        Busy;

    int compared;
    int mismatched;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_MUL = 4'b0001;
    localparam logic [3:0] OP_DIV = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;

    alu_writeback dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .In_Valid     (In_Valid),
        .In_Ready     (In_Ready),
        .ALU_Ctrl     (ALU_Ctrl),
        .R            (R),
        .S            (S),
        .ALU_Exception(ALU_Exception),
        .Dest         (Dest),
        .Wr_En        (Wr_En),
        .Wr_Addr      (Wr_Addr),
        .Wr_Data      (Wr_Data),
        .Exc_Flag     (Exc_Flag),
        .Exc_Ctrl     (Exc_Ctrl),
        .Exc_Clear    (Exc_Clear),
        .Busy         (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic valid, input logic [3:0] ctrl, input logic [15:0] r,
                         input logic [15:0] s, input logic exc, input logic [3:0] dest);
        In_Valid      = valid;
        ALU_Ctrl      = ctrl;
        R             = r;
        S             = s;
        ALU_Exception = exc;
        Dest          = dest;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        Exc_Clear = 1'b0;
        drive(1'b0, OP_NOP, 16'h0000, 16'h0000, 1'b0, 4'd0);
        repeat (3) @(negedge clk);
        compared++;
        if ({In_Ready, Wr_En, Busy, Exc_Flag} !== 4'b1000) begin
            mismatched++;
            $display("[TB] FAIL reset_flags: got %b expected 1000", {In_Ready, Wr_En, Busy, Exc_Flag});
        end
        compared++;
        if ({Wr_Addr, Wr_Data, Exc_Ctrl} !== 24'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_regs: got %h expected 000000", {Wr_Addr, Wr_Data, Exc_Ctrl});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_add();
        drive(1'b1, OP_ADD, 16'h0005, 16'hDEAD, 1'b0, 4'd3);
        @(negedge clk);
        In_Valid = 1'b0;
        compared++;
        if ({Wr_En, Wr_Addr, Wr_Data} !== {1'b1, 4'd3, 16'h0005}) begin
            mismatched++;
            $display("[TB] FAIL add_write: got %b/%h/%h expected 1/3/0005", Wr_En, Wr_Addr, Wr_Data);
        end
        compared++;
        if (Busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL add_busy: got %b expected 1", Busy);
        end
        @(negedge clk);
        compared++;
        if ({Wr_En, Busy} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL add_after: got en=%b busy=%b expected 0/0", Wr_En, Busy);
        end
    endtask

    task automatic test_double(input logic [3:0] op, input logic [3:0] dest,
                               input logic [15:0] r, input logic [15:0] s);
        drive(1'b1, op, r, s, 1'b0, dest);
        @(negedge clk);
        In_Valid = 1'b0;
        compared++;
        if ({Wr_En, Wr_Addr, Wr_Data, In_Ready} !== {1'b1, dest, r, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL double_lo: got %b/%h/%h rdy=%b expected 1/%h/%h rdy=0",
                     Wr_En, Wr_Addr, Wr_Data, In_Ready, dest, r);
        end
        @(negedge clk);
        compared++;
        if ({Wr_En, Wr_Addr, Wr_Data, In_Ready} !== {1'b1, 4'd15, s, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL double_hi: got %b/%h/%h rdy=%b expected 1/f/%h rdy=0",
                     Wr_En, Wr_Addr, Wr_Data, In_Ready, s);
        end
        @(negedge clk);
        compared++;
        if ({Wr_En, Busy, In_Ready} !== 3'b001) begin
            mismatched++;
            $display("[TB] FAIL double_done: got en/busy/rdy=%b expected 001", {Wr_En, Busy, In_Ready});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops  [3] = '{OP_AND, OP_OR, OP_SUB};
        logic [15:0] vals [3] = '{16'h00F0, 16'h0F0F, 16'hFFFE};
        logic [3:0]  dsts [3] = '{4'd7, 4'd8, 4'd9};
        drive(1'b1, ops[0], vals[0], 16'h0000, 1'b0, dsts[0]);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (In_Ready !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL b2b_ready[%0d]: got %b expected 1", i, In_Ready);
            end
            @(negedge clk);
            if (i < 2) drive(1'b1, ops[i+1], vals[i+1], 16'h0000, 1'b0, dsts[i+1]);
            else In_Valid = 1'b0;
            compared++;
            if ({Wr_En, Wr_Addr, Wr_Data} !== {1'b1, dsts[i], vals[i]}) begin
                mismatched++;
                $display("[TB] FAIL b2b_write[%0d]: got %b/%h/%h expected 1/%h/%h",
                         i, Wr_En, Wr_Addr, Wr_Data, dsts[i], vals[i]);
            end
        end
        @(negedge clk);
        compared++;
        if (Wr_En !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_after: got %b expected 0", Wr_En);
        end
    endtask

    task automatic test_exception();
        drive(1'b1, OP_DIV, 16'h1234, 16'h5678, 1'b1, 4'd1);
        @(negedge clk);
        drive(1'b1, OP_ADD, 16'h00AA, 16'h0000, 1'b0, 4'd4);
        compared++;
        if ({Exc_Flag, Exc_Ctrl, Busy} !== {1'b1, 4'b0010, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL exc_latch: got flag=%b ctrl=%b busy=%b expected 1/0010/1",
                     Exc_Flag, Exc_Ctrl, Busy);
        end
        // In_Valid is held high the whole time; nothing may be accepted or written.
        for (int i = 0; i < 10; i++) begin
            compared++;
            if ({In_Ready, Wr_En, Exc_Flag} !== 3'b001) begin
                mismatched++;
                $display("[TB] FAIL exc_hold[%0d]: got rdy/en/flag=%b expected 001",
                         i, {In_Ready, Wr_En, Exc_Flag});
            end
            @(negedge clk);
        end
        Exc_Clear = 1'b1;
        @(negedge clk);
        Exc_Clear = 1'b0;
        compared++;
        if ({Exc_Flag, Busy, Wr_En, In_Ready, Exc_Ctrl} !== {4'b0001, 4'b0010}) begin
            mismatched++;
            $display("[TB] FAIL exc_clear: got flag/busy/en/rdy=%b ctrl=%b expected 0001/0010",
                     {Exc_Flag, Busy, Wr_En, In_Ready}, Exc_Ctrl);
        end
        @(negedge clk);
        In_Valid = 1'b0;
        compared++;
        if ({Wr_En, Wr_Addr, Wr_Data} !== {1'b1, 4'd4, 16'h00AA}) begin
            mismatched++;
            $display("[TB] FAIL exc_resume: got %b/%h/%h expected 1/4/00aa", Wr_En, Wr_Addr, Wr_Data);
        end
        @(negedge clk);
    endtask

    task automatic test_nop();
        Exc_Clear = 1'b1;
        drive(1'b1, OP_NOP, 16'h1234, 16'h4321, 1'b0, 4'd5);
        @(negedge clk);
        In_Valid  = 1'b0;
        Exc_Clear = 1'b0;
        compared++;
        if ({Wr_En, Busy, In_Ready, Exc_Flag} !== 4'b0010) begin
            mismatched++;
            $display("[TB] FAIL nop: got en/busy/rdy/flag=%b expected 0010", {Wr_En, Busy, In_Ready, Exc_Flag});
        end
        @(negedge clk);
        compared++;
        if ({Wr_En, Busy} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL nop_after: got en/busy=%b expected 00", {Wr_En, Busy});
        end
    endtask

    task automatic test_reset_mid_write();
        drive(1'b1, OP_DIV, 16'h0007, 16'h0003, 1'b0, 4'd6);
        @(negedge clk);
        In_Valid = 1'b0;
        compared++;
        if ({Wr_En, Wr_Addr} !== {1'b1, 4'd6}) begin
            mismatched++;
            $display("[TB] FAIL rst_pre: got %b/%h expected 1/6", Wr_En, Wr_Addr);
        end
        #1 rst_n = 1'b0;
        #1;
        compared++;
        if ({Wr_En, Busy, In_Ready, Exc_Flag, Wr_Addr, Wr_Data, Exc_Ctrl} !== {4'b0010, 24'h0}) begin
            mismatched++;
            $display("[TB] FAIL rst_mid: got %b/%h/%h/%h expected 0010/0/0000/0",
                     {Wr_En, Busy, In_Ready, Exc_Flag}, Wr_Addr, Wr_Data, Exc_Ctrl);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            compared++;
            if (Wr_En !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rst_no_hi[%0d]: got wr_en=%b addr=%h expected 0", i, Wr_En, Wr_Addr);
            end
        end
    endtask

    task automatic test_reset_in_halt();
        drive(1'b1, OP_SUB, 16'h8000, 16'h0000, 1'b1, 4'd2);
        @(negedge clk);
        In_Valid = 1'b0;
        compared++;
        if ({Exc_Flag, Exc_Ctrl} !== {1'b1, OP_SUB}) begin
            mismatched++;
            $display("[TB] FAIL halt_pre: got %b/%b expected 1/0100", Exc_Flag, Exc_Ctrl);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({Exc_Flag, Exc_Ctrl, Busy, In_Ready} !== {1'b0, 4'b0000, 2'b01}) begin
            mismatched++;
            $display("[TB] FAIL halt_rst: got flag=%b ctrl=%b busy/rdy=%b expected 0/0000/01",
                     Exc_Flag, Exc_Ctrl, {Busy, In_Ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_single_add();
        test_double(OP_MUL, 4'd2, 16'h2000, 16'h0001);
        test_double(OP_DIV, 4'd15, 16'h1111, 16'h2222);
        test_back_to_back();
        test_exception();
        test_nop();
        test_reset_mid_write();
        test_reset_in_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
